// File: rtl/uart_echo_fifo.sv
`timescale 1ns / 1ps
// uart_echo_fifo
// UART loopback engine: receiver -> FIFO -> transmitter.
// Characters are deserialised from rx. Good characters are buffered and
// re-serialised on tx in arrival order.
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   rx          serial input, idle high, asynchronous to clock
//   tx_en       1 = transmitter may pop the FIFO, 0 = hold buffered data
//   clear       one-cycle pulse, clears the sticky flags
//   tx          serial output, idle high
//   led         last character accepted into the FIFO
//   fifo_count  current FIFO occupancy
//   overflow    sticky: good character dropped because the FIFO was full
//   parity_err  sticky: frame failed its parity check
//   frame_err   sticky: stop bit sampled low
module uart_echo_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,   // 0 none, 1 odd, 2 even
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          rx,
  input  logic                          tx_en,
  input  logic                          clear,
  output logic                          tx,
  output logic [DATA_BITS-1:0]          led,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(FIFO_DEPTH);
  localparam logic          PAR_EN   = (PARITY != 0);
  localparam logic          PAR_ODD  = (PARITY == 1);

  // ---------------------------------------------------------------------
  // rx synchroniser plus edge register
  // ---------------------------------------------------------------------
  logic rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic rx_fall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  assign rx_fall = rx_prev_reg & ~rx_sync_reg;

  // ---------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_t;

  rx_state_t              rx_state_reg;
  logic [CW-1:0]          rx_cnt_reg;
  logic [BW-1:0]          rx_bit_reg;
  logic [DATA_BITS-1:0]   rx_shift_reg;
  logic                   rx_par_reg;
  logic                   push_req_reg;
  logic [DATA_BITS-1:0]   push_data_reg;

  logic rx_stop_sample;
  logic rx_par_bad;
  logic frame_set, parity_set;

  assign rx_stop_sample = (rx_state_reg == RX_STOP) && (rx_cnt_reg == CNT_LAST);
  assign rx_par_bad     = PAR_EN && (rx_par_reg != ((^rx_shift_reg) ^ PAR_ODD));
  // Frame error takes priority over a parity error on the same frame.
  assign frame_set      = rx_stop_sample && !rx_sync_reg;
  assign parity_set     = rx_stop_sample && rx_sync_reg && rx_par_bad;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_reg  <= RX_IDLE;
      rx_cnt_reg    <= '0;
      rx_bit_reg    <= '0;
      rx_shift_reg  <= '0;
      rx_par_reg    <= 1'b0;
      push_req_reg  <= 1'b0;
      push_data_reg <= '0;
    end else begin
      push_req_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state_reg <= RX_START;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_reg == CNT_HALF) begin
            rx_cnt_reg   <= '0;
            // Line already back high at mid-start: treat as a glitch.
            rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == CNT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
            if (rx_bit_reg == BIT_LAST) begin
              rx_state_reg <= PAR_EN ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_reg <= rx_bit_reg + BW'(1);
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CW'(1);
          end
        end
        RX_PARITY: begin
          if (rx_cnt_reg == CNT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_par_reg   <= rx_sync_reg;
            rx_state_reg <= RX_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == CNT_LAST) begin
            rx_cnt_reg <= '0;
            if (rx_sync_reg) begin
              rx_state_reg <= RX_IDLE;
              if (!rx_par_bad) begin
                push_req_reg  <= 1'b1;
                push_data_reg <= rx_shift_reg;
              end
            end else begin
              // Break or framing fault: one error, then wait for idle line.
              rx_state_reg <= RX_BREAK;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CW'(1);
          end
        end
        RX_BREAK: begin
          if (rx_sync_reg) rx_state_reg <= RX_IDLE;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]          count_reg;
  logic [DATA_BITS-1:0] rd_data_reg;
  logic [DATA_BITS-1:0] led_reg;
  logic                 overflow_reg, parity_err_reg, frame_err_reg;

  logic fifo_full, fifo_empty, push, pop, overflow_set;
  logic tx_idle;

  assign fifo_full    = (count_reg == DEPTH_W);
  assign fifo_empty   = (count_reg == '0);
  assign pop          = tx_idle && tx_en && !fifo_empty;
  // A pop in the same cycle frees a slot, so a push at full is still taken.
  assign push         = push_req_reg && (!fifo_full || pop);
  assign overflow_set = push_req_reg && fifo_full && !pop;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= push_data_reg;
  end

  // Registered read; data is needed only at the end of the start bit.
  always_ff @(posedge clock) begin
    if (pop) rd_data_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      led_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
        led_reg    <= push_data_reg;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky flags: a set event wins over a coincident clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      if (overflow_set)    overflow_reg   <= 1'b1;
      else if (clear)      overflow_reg   <= 1'b0;
      if (parity_set)      parity_err_reg <= 1'b1;
      else if (clear)      parity_err_reg <= 1'b0;
      if (frame_set)       frame_err_reg  <= 1'b1;
      else if (clear)      frame_err_reg  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Transmitter FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  tx_state_t            tx_state_reg;
  logic [CW-1:0]        tx_cnt_reg;
  logic [BW-1:0]        tx_bit_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_par_reg;
  logic                 tx_reg;

  assign tx_idle = (tx_state_reg == TX_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          tx_reg <= 1'b1;
          if (pop) begin
            tx_state_reg <= TX_START;
            tx_cnt_reg   <= '0;
            tx_reg       <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt_reg == CNT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_reg       <= rd_data_reg[0];
            // Shift holds the bits still to be sent, next one at bit 0.
            tx_shift_reg <= rd_data_reg >> 1;
            tx_par_reg   <= (^rd_data_reg) ^ PAR_ODD;
            tx_state_reg <= TX_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_reg == CNT_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == BIT_LAST) begin
              if (PAR_EN) begin
                tx_reg       <= tx_par_reg;
                tx_state_reg <= TX_PARITY;
              end else begin
                tx_reg       <= 1'b1;
                tx_state_reg <= TX_STOP;
              end
            end else begin
              tx_bit_reg   <= tx_bit_reg + BW'(1);
              tx_reg       <= tx_shift_reg[0];
              tx_shift_reg <= tx_shift_reg >> 1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        TX_PARITY: begin
          if (tx_cnt_reg == CNT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_reg       <= 1'b1;
            tx_state_reg <= TX_STOP;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_reg == CNT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_state_reg <= TX_IDLE;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        default: begin
          tx_state_reg <= TX_IDLE;
          tx_reg       <= 1'b1;
        end
      endcase
    end
  end

  assign tx         = tx_reg;
  assign led        = led_reg;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_uart_echo_fifo.sv
`timescale 1ns / 1ps
// Bench for uart_echo_fifo: one instance without parity (u0) and one with
// even parity (u2). A line-level UART decoder watches each tx pin and checks
// every decoded frame against a queue of characters the model expects.
module tb_uart_echo_fifo;

  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n = 1'b1;
  logic       rx0 = 1'b1, rx2 = 1'b1;
  logic       tx_en0 = 1'b1, tx_en2 = 1'b1;
  logic       clear0 = 1'b0, clear2 = 1'b0;
  logic       tx0, tx2;
  logic [7:0] led0, led2;
  logic [4:0] cnt0, cnt2;
  logic       ovf0, pe0, fe0, ovf2, pe2, fe2;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q2[$];
  bit         quiet0 = 1'b0;

  uart_echo_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(0), .FIFO_DEPTH(DEPTH)) u0 (
    .clock(clock), .reset_n(reset_n), .rx(rx0), .tx_en(tx_en0), .clear(clear0),
    .tx(tx0), .led(led0), .fifo_count(cnt0),
    .overflow(ovf0), .parity_err(pe0), .frame_err(fe0)
  );

  uart_echo_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(2), .FIFO_DEPTH(DEPTH)) u2 (
    .clock(clock), .reset_n(reset_n), .rx(rx2), .tx_en(tx_en2), .clear(clear2),
    .tx(tx2), .led(led2), .fifo_count(cnt2),
    .overflow(ovf2), .parity_err(pe2), .frame_err(fe2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input int sel, input logic v, input int cycles);
    if (sel == 0) rx0 = v; else rx2 = v;
    wait_cyc(cycles);
  endtask

  // Start, 8 data bits LSB first, even parity on u2 (optionally wrong), stop.
  task automatic send_frame(input int sel, input logic [7:0] d, input bit bad_par, input logic stop);
    drive_bit(sel, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], CPB);
    if (sel == 2) drive_bit(sel, (^d) ^ bad_par, CPB);
    drive_bit(sel, stop, CPB);
  endtask

  task automatic pulse_clear(input int sel);
    if (sel == 0) clear0 = 1'b1; else clear2 = 1'b1;
    @(negedge clock);
    clear0 = 1'b0;
    clear2 = 1'b0;
  endtask

  // Decode one frame from tx, starting just after its falling edge.
  task automatic mon_frame(input int sel);
    logic [7:0] d;
    logic       st, par, sp;
    logic [7:0] e;
    wait_cyc(CPB / 2);
    st = (sel == 0) ? tx0 : tx2;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(CPB);
      d[i] = (sel == 0) ? tx0 : tx2;
    end
    par = 1'b0;
    if (sel == 2) begin
      wait_cyc(CPB);
      par = tx2;
    end
    wait_cyc(CPB);
    sp = (sel == 0) ? tx0 : tx2;
    if (!(sel == 0 && quiet0)) begin
      check_eq($sformatf("tx%0d_start_bit", sel), st, 0);
      check_eq($sformatf("tx%0d_stop_bit", sel), sp, 1);
      if (sel == 2) check_eq("tx2_parity_bit", par, ^d);
      if (sel == 0) begin
        check_eq("tx0_expected_frame", exp_q0.size() != 0, 1);
        if (exp_q0.size() != 0) begin
          e = exp_q0.pop_front();
          check_eq("tx0_data", d, e);
        end
      end else begin
        check_eq("tx2_expected_frame", exp_q2.size() != 0, 1);
        if (exp_q2.size() != 0) begin
          e = exp_q2.pop_front();
          check_eq("tx2_data", d, e);
        end
      end
    end
  endtask

  initial forever begin
    @(negedge tx0);
    mon_frame(0);
  end

  initial forever begin
    @(negedge tx2);
    mon_frame(2);
  end

  task automatic wait_drain(input int sel, input int limit);
    int k;
    k = 0;
    while (((sel == 0) ? exp_q0.size() : exp_q2.size()) != 0 && k < limit) begin
      @(negedge clock);
      k++;
    end
    if (k >= limit)
      check_eq($sformatf("drain%0d_left", sel), (sel == 0) ? exp_q0.size() : exp_q2.size(), 0);
    wait_cyc(2 * CPB);
  endtask

  initial begin
    repeat (60000) @(posedge clock);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    logic [7:0] d;
    bit         bad, saw_low;

    #1 reset_n = 1'b0;
    wait_cyc(3);
    check_eq("rst_tx", tx0, 1);
    check_eq("rst_led", led0, 0);
    check_eq("rst_count", cnt0, 0);
    check_eq("rst_flags", {ovf0, pe0, fe0}, 0);
    check_eq("rst_tx2", tx2, 1);
    reset_n = 1'b1;
    wait_cyc(4);

    // Single echo with start-latency check.
    exp_q0.push_back(8'h55);
    fork
      send_frame(0, 8'h55, 1'b0, 1'b1);
    join_none
    k = 0;
    while (cnt0 != 1 && k < 400) begin
      @(negedge clock);
      k++;
    end
    check_eq("t1_count_push", cnt0, 1);
    check_eq("t1_led", led0, 8'h55);
    check_eq("t1_tx_before_pop", tx0, 1);
    @(negedge clock);
    check_eq("t1_tx_start_latency", tx0, 0);
    check_eq("t1_count_pop", cnt0, 0);
    wait_drain(0, 2000);
    check_eq("t1_count_end", cnt0, 0);

    // Fill past capacity with transmit held.
    tx_en0 = 1'b0;
    for (int b = 0; b <= 16; b++) begin
      if (b < 16) exp_q0.push_back(8'(b));
      send_frame(0, 8'(b), 1'b0, 1'b1);
    end
    wait_cyc(4);
    check_eq("ovf_count", cnt0, 16);
    check_eq("ovf_flag", ovf0, 1);
    check_eq("ovf_led", led0, 8'h0F);
    check_eq("ovf_tx_held", tx0, 1);
    tx_en0 = 1'b1;
    k = 0;
    while (cnt0 != 15 && k < 100) begin
      @(negedge clock);
      k++;
    end
    wait_cyc(2);
    tx_en0 = 1'b0;   // must not abort the frame in flight
    wait_cyc(300);
    check_eq("txen_drop_count", cnt0, 15);
    tx_en0 = 1'b1;
    wait_drain(0, 16 * 250);
    check_eq("drain_count", cnt0, 0);
    check_eq("drain_tx_idle", tx0, 1);
    pulse_clear(0);
    check_eq("ovf_cleared", ovf0, 0);

    // Wrong parity on u2.
    send_frame(2, 8'hA3, 1'b1, 1'b1);
    wait_cyc(4);
    check_eq("par_flag", pe2, 1);
    check_eq("par_count", cnt2, 0);
    wait_cyc(200);
    pulse_clear(2);
    check_eq("par_cleared", pe2, 0);

    // Break on u2: 3 frame times low, one error only.
    rx2 = 1'b0;
    wait_cyc(CPB * 11 * 3 / 2);
    check_eq("brk_flag", fe2, 1);
    pulse_clear(2);
    wait_cyc(CPB * 11 * 3 / 2);
    check_eq("brk_single", fe2, 0);
    rx2 = 1'b1;
    wait_cyc(2 * CPB);
    exp_q2.push_back(8'h3C);
    send_frame(2, 8'h3C, 1'b0, 1'b1);
    check_eq("brk_led", led2, 8'h3C);
    wait_drain(2, 2000);
    check_eq("brk_count", cnt2, 0);

    // Short low glitch on u0.
    rx0 = 1'b0;
    wait_cyc(CPB / 4);
    rx0 = 1'b1;
    wait_cyc(12 * CPB);
    check_eq("glitch_flags", {ovf0, pe0, fe0}, 0);
    check_eq("glitch_count", cnt0, 0);
    check_eq("glitch_led", led0, 8'h0F);
    check_eq("glitch_tx", tx0, 1);

    // Random frames on u0, including back-to-back.
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      exp_q0.push_back(d);
      send_frame(0, d, 1'b0, 1'b1);
      check_eq("rnd0_led", led0, d);
      wait_cyc($urandom_range(0, 2 * CPB));
    end
    wait_drain(0, 4000);
    check_eq("rnd0_count", cnt0, 0);

    // Random frames on u2 with occasional parity faults.
    for (int i = 0; i < 24; i++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      if (!bad) exp_q2.push_back(d);
      send_frame(2, d, bad, 1'b1);
      check_eq("rnd2_parity_flag", pe2, bad);
      if (bad) pulse_clear(2);
      else check_eq("rnd2_led", led2, d);
      wait_cyc($urandom_range(0, 2 * CPB));
    end
    wait_drain(2, 4000);
    check_eq("rnd2_count", cnt2, 0);
    check_eq("rnd2_frame_flag", fe2, 0);

    // Stop bit low on u0.
    send_frame(0, 8'h5A, 1'b0, 1'b0);
    rx0 = 1'b1;
    wait_cyc(4 * CPB);
    check_eq("stop_frame_flag", fe0, 1);
    check_eq("stop_count", cnt0, 0);

    // Reset in the middle of a transmit with entries queued.
    tx_en0 = 1'b0;
    send_frame(0, 8'h81, 1'b0, 1'b1);
    send_frame(0, 8'h11, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    send_frame(0, 8'h33, 1'b0, 1'b1);
    wait_cyc(4);
    check_eq("rstq_count", cnt0, 4);
    quiet0 = 1'b1;
    tx_en0 = 1'b1;
    k = 0;
    while (cnt0 != 3 && k < 100) begin
      @(negedge clock);
      k++;
    end
    wait_cyc(4 * CPB);
    check_eq("rstq_fe_before", fe0, 1);
    reset_n = 1'b0;
    @(negedge clock);
    check_eq("rstq_tx", tx0, 1);
    check_eq("rstq_count0", cnt0, 0);
    check_eq("rstq_flags", {ovf0, pe0, fe0}, 0);
    check_eq("rstq_led", led0, 0);
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(12 * CPB);
    quiet0 = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 30 * CPB; i++) begin
      @(negedge clock);
      if (tx0 == 1'b0) saw_low = 1'b1;
    end
    check_eq("rstq_no_output", saw_low, 0);
    check_eq("rstq_count_after", cnt0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
